// File: rtl/sram_access_pkg.sv
// Shared types and default sizing for the asynchronous SRAM access driver.
package sram_access_pkg;

  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;
  localparam int RD_WAIT = 14;
  localparam int WR_WAIT = 14;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    READ,
    WRITE,
    HOLD
  } state_t;

endpackage

// File: rtl/sram_wait_timer.sv
// Loadable wait counter: counts up while enabled and parks on the limit value.
module sram_wait_timer
  import sram_access_pkg::*;
#(
  parameter int CNT_W = sram_access_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  assign done = (cnt == limit);

  // Holding at the limit keeps the counter from wrapping if the FSM lingers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && !done) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_access_driver.sv
// Strobe/address/data sequencer for one asynchronous SRAM, single read or write per request.
// Define SRAM_ACCESS_WRACK_EN to also pulse rsp_valid when a write completes.
module sram_access_driver
  import sram_access_pkg::*;
#(
  parameter int ADDR_W  = sram_access_pkg::ADDR_W,
  parameter int DATA_W  = sram_access_pkg::DATA_W,
  parameter int CNT_W   = sram_access_pkg::CNT_W,
  parameter int RD_WAIT = sram_access_pkg::RD_WAIT,
  parameter int WR_WAIT = sram_access_pkg::WR_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_e_n,
  output logic              sram_o_n,
  output logic              sram_w_n,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in
);

  generate
    if (RD_WAIT < 1 || RD_WAIT > (2**CNT_W) - 1) begin : g_bad_rd_wait
      $error("RD_WAIT out of range for CNT_W");
    end
    if (WR_WAIT < 1 || WR_WAIT > (2**CNT_W) - 1) begin : g_bad_wr_wait
      $error("WR_WAIT out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(RD_WAIT);
  localparam logic [CNT_W-1:0] WR_LIM = CNT_W'(WR_WAIT);

  state_t           state;
  logic             we_q;
  logic             tmr_clr;
  logic             tmr_en;
  logic             tmr_done;
  logic [CNT_W-1:0] tmr_limit;
  logic [CNT_W-1:0] tmr_cnt;

  assign tmr_clr   = (state == IDLE) || (state == SETUP);
  assign tmr_en    = (state == READ) || (state == WRITE);
  assign tmr_limit = we_q ? WR_LIM : RD_LIM;

  sram_wait_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (tmr_clr),
    .load     (1'b0),
    .en       (tmr_en),
    .load_val ('0),
    .limit    (tmr_limit),
    .cnt      (tmr_cnt),
    .done     (tmr_done)
  );

  // Outputs are assigned for the state being entered, so every pin is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      sram_addr   <= '0;
      sram_e_n    <= 1'b1;
      sram_o_n    <= 1'b1;
      sram_w_n    <= 1'b1;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            state     <= SETUP;
            we_q      <= req_we;
            sram_addr <= req_addr;
            sram_e_n  <= 1'b0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            if (req_we) begin
              sram_dq_out <= req_wdata;
            end
          end
        end
        SETUP: begin
          if (we_q) begin
            state      <= WRITE;
            sram_w_n   <= 1'b0;
            sram_dq_oe <= 1'b1;
          end else begin
            state    <= READ;
            sram_o_n <= 1'b0;
          end
        end
        READ: begin
          if (tmr_done) begin
            state     <= HOLD;
            sram_o_n  <= 1'b1;
            rsp_rdata <= sram_dq_in;
          end
        end
        WRITE: begin
          // dq_oe stays high into HOLD to give data hold past the W_n rising edge.
          if (tmr_done) begin
            state    <= HOLD;
            sram_w_n <= 1'b1;
          end
        end
        HOLD: begin
          state      <= IDLE;
          sram_e_n   <= 1'b1;
          sram_dq_oe <= 1'b0;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
`ifdef SRAM_ACCESS_WRACK_EN
          rsp_valid  <= 1'b1;
`else
          rsp_valid  <= ~we_q;
`endif
        end
        default: begin
          state      <= IDLE;
          sram_e_n   <= 1'b1;
          sram_o_n   <= 1'b1;
          sram_w_n   <= 1'b1;
          sram_dq_oe <= 1'b0;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_driver.sv
// Scoreboard bench: default-timing driver (dut 0) and minimum-timing driver (dut 1).
module tb_sram_access_driver;

`ifdef SRAM_ACCESS_WRACK_EN
  localparam bit WRACK = 1'b1;
`else
  localparam bit WRACK = 1'b0;
`endif

  typedef struct {
    int         dut;
    logic [7:0] data;
    int         when;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_we;
  logic [16:0] req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  dq_in;
  logic        req_valid [2];
  logic        ready     [2];
  logic        rsp_valid [2];
  logic [7:0]  rdata     [2];
  logic        busy      [2];
  logic [16:0] addr      [2];
  logic        e_n       [2];
  logic        o_n       [2];
  logic        w_n       [2];
  logic [7:0]  dq_out    [2];
  logic        oe        [2];

  int          cyc;
  int          checks;
  int          errors;
  exp_t        sbq[$];
  logic [16:0] exp_addr  [2];
  logic [7:0]  exp_wdata [2];
  logic [7:0]  last_rd   [2];

  sram_access_driver u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(ready[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rdata[0]), .busy(busy[0]),
    .sram_addr(addr[0]), .sram_e_n(e_n[0]), .sram_o_n(o_n[0]), .sram_w_n(w_n[0]),
    .sram_dq_out(dq_out[0]), .sram_dq_oe(oe[0]), .sram_dq_in(dq_in)
  );

  sram_access_driver #(.RD_WAIT(1), .WR_WAIT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(ready[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rdata[1]), .busy(busy[1]),
    .sram_addr(addr[1]), .sram_e_n(e_n[1]), .sram_o_n(o_n[1]), .sram_w_n(w_n[1]),
    .sram_dq_out(dq_out[1]), .sram_dq_oe(oe[1]), .sram_dq_in(dq_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rdw(input int d);
    return (d == 0) ? 14 : 1;
  endfunction

  function automatic int wrw(input int d);
    return (d == 0) ? 14 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: pops the scoreboard whenever a driver presents rsp_valid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rsp_valid[d] === 1'b1) begin
          if (sbq.size() == 0 || sbq[0].dut != d) begin
            check("unexpected_rsp_valid", 32'(d), 32'hFFFF_FFFF);
          end else begin
            e = sbq.pop_front();
            check("rsp_rdata", 32'(rdata[d]), 32'(e.data));
            check("rsp_latency", 32'(cyc), 32'(e.when));
          end
        end
      end
    end
  end

  // Strobe monitor: pulse widths, exclusivity and stable address/data during access.
  initial begin
    int o_run [2];
    int w_run [2];
    o_run = '{0, 0};
    w_run = '{0, 0};
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          o_run[d] = 0;
          w_run[d] = 0;
        end else begin
          if (!e_n[d]) check("addr_stable", 32'(addr[d]), 32'(exp_addr[d]));
          if (!o_n[d]) begin
            o_run[d]++;
            check("w_n_high_while_o_n_low", 32'(w_n[d]), 32'd1);
            check("dq_oe_low_while_o_n_low", 32'(oe[d]), 32'd0);
          end else if (o_run[d] != 0) begin
            check("o_n_low_cycles", 32'(o_run[d]), 32'(rdw(d) + 1));
            o_run[d] = 0;
          end
          if (!w_n[d]) begin
            w_run[d]++;
            check("dq_oe_in_write", 32'(oe[d]), 32'd1);
            check("dq_out_in_write", 32'(dq_out[d]), 32'(exp_wdata[d]));
          end else if (w_run[d] != 0) begin
            check("w_n_low_cycles", 32'(w_run[d]), 32'(wrw(d) + 1));
            check("dq_oe_held_in_hold", 32'(oe[d]), 32'd1);
            check("e_n_low_in_hold", 32'(e_n[d]), 32'd0);
            w_run[d] = 0;
          end
        end
      end
    end
  end

  task automatic issue(input int d, input logic we, input logic [16:0] a,
                       input logic [7:0] wd, input logic [7:0] rd,
                       input bit push, input bit keep, output int acc);
    int n;
    @(negedge clk);
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    if (!we) dq_in = rd;
    req_valid[d] = 1'b1;
    n = 0;
    while (ready[d] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (ready[d] !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready=%0b, expected 1", ready[d]);
      req_valid[d] = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc + 1;
    exp_addr[d] = a;
    if (we) begin
      exp_wdata[d] = wd;
      if (WRACK && push) sbq.push_back('{d, last_rd[d], acc + wrw(d) + 3});
    end else if (push) begin
      last_rd[d] = rd;
      sbq.push_back('{d, rd, acc + rdw(d) + 3});
    end
    @(negedge clk);
    if (!keep) req_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int a1, a2, a3;
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst    = 1'b1;
    req_valid = '{1'b0, 1'b0};
    req_we = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    dq_in = '0;
    exp_addr = '{17'h0, 17'h0};
    exp_wdata = '{8'h0, 8'h0};
    last_rd = '{8'h0, 8'h0};
    repeat (3) @(negedge clk);

    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", 32'(ready[d]), 32'd1);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      check("rst_rsp_rdata", 32'(rdata[d]), 32'd0);
      check("rst_strobes", {29'd0, e_n[d], o_n[d], w_n[d]}, 32'h7);
      check("rst_dq_oe", 32'(oe[d]), 32'd0);
      check("rst_sram_addr", 32'(addr[d]), 32'd0);
      check("rst_dq_out", 32'(dq_out[d]), 32'd0);
    end
    #2 rst = 1'b0;

    issue(0, 1'b0, 17'h1A2B3, 8'h00, 8'hC5, 1'b1, 1'b0, a1);
    check("busy_during_read", 32'(busy[0]), 32'd1);
    check("ready_low_during_read", 32'(ready[0]), 32'd0);
    drain();

    issue(0, 1'b1, 17'h00010, 8'h5A, 8'h00, 1'b1, 1'b0, a1);
    drain();
    check("rdata_kept_after_write", 32'(rdata[0]), 32'hC5);

    // Back-to-back with req_valid held and inputs changing mid-access.
    issue(0, 1'b0, 17'h0AAAA, 8'h00, 8'h3C, 1'b1, 1'b1, a1);
    issue(0, 1'b1, 17'h1FFFF, 8'h96, 8'h00, 1'b1, 1'b1, a2);
    issue(0, 1'b0, 17'h00001, 8'h00, 8'h81, 1'b1, 1'b0, a3);
    check("b2b_gap_after_read", 32'(a2 - a1), 32'd18);
    check("b2b_gap_after_write", 32'(a3 - a2), 32'd18);
    drain();

    // Reset while READ counter is 7: aborted read, no response.
    issue(0, 1'b0, 17'h0F0F0, 8'h00, 8'h99, 1'b0, 1'b0, a1);
    repeat (8) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_strobes_high", {29'd0, e_n[0], o_n[0], w_n[0]}, 32'h7);
    check("abort_dq_oe", 32'(oe[0]), 32'd0);
    check("abort_busy", 32'(busy[0]), 32'd0);
    check("abort_req_ready", 32'(ready[0]), 32'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    last_rd[0] = 8'h00;
    repeat (20) @(negedge clk);

    issue(0, 1'b0, 17'h12345, 8'h00, 8'hE7, 1'b1, 1'b0, a1);
    drain();
    issue(0, 1'b1, 17'h00F0F, 8'hFF, 8'h00, 1'b1, 1'b0, a1);
    drain();
    check("rdata_kept_after_ff_write", 32'(rdata[0]), 32'hE7);

    // Minimum wait counts.
    issue(1, 1'b0, 17'h00ABC, 8'h00, 8'h42, 1'b1, 1'b0, a1);
    drain();
    issue(1, 1'b1, 17'h00003, 8'h11, 8'h00, 1'b1, 1'b1, a1);
    issue(1, 1'b0, 17'h1C001, 8'h00, 8'hA5, 1'b1, 1'b0, a2);
    check("min_b2b_gap_after_write", 32'(a2 - a1), 32'd5);
    drain();
    check("min_rdata_final", 32'(rdata[1]), 32'hA5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
